// File: rtl/parallelizer.sv
// Packs a serial pixel stream into bursts of PIXELS_PER_BURST pixels, aligned to start of frame,
// with frame-start, row-end and frame-end markers on the burst side.
module parallelizer #(
    parameter int PIXEL_BIT_WIDTH  = 10,
    parameter int PIXELS_PER_BURST = 10,
    parameter int USER_WIDTH       = 2,
    parameter int ROWS             = 20,
    parameter int COLS             = 20
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]                  s_axis_tdata,
    input  logic [USER_WIDTH-1:0]                       s_axis_tuser,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] m_axis_tdata,
    output logic [USER_WIDTH-1:0]                       m_axis_tuser,
    output logic                                        m_axis_tlast,
    output logic [$clog2(COLS)-1:0]                     cnt_col,
    output logic [$clog2(ROWS)-1:0]                     cnt_row,
    output logic                                        frame_err
);

    localparam int W   = PIXEL_BIT_WIDTH;
    localparam int PPB = PIXELS_PER_BURST;
    localparam int DW  = W * PPB;
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int IW  = $clog2(PPB);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t                state;
    logic                  running;
    logic [IW-1:0]         cnt_idx_in_burst;
    logic [W-1:0]          buffer [PPB-1];
    logic                  first_flag;

    logic                  stall;
    logic                  accept;
    logic                  sof;
    logic                  take;
    logic                  is_final;
    logic                  m_done;
    logic [CW-1:0]         pos_col;
    logic [RW-1:0]         pos_row;
    logic [IW-1:0]         pos_idx;
    logic [DW-1:0]         load_data;
    logic [USER_WIDTH-1:0] load_user;
    logic                  load_last;

    // Only the final pixel of a burst needs room in the output register.
    assign stall         = (state == ACTIVE) && (cnt_idx_in_burst == IW'(PPB - 1))
                           && m_axis_tvalid && !m_axis_tready;
    assign s_axis_tready = running && !stall;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign sof           = s_axis_tuser[0];
    assign take          = accept && ((state == ACTIVE) || sof);
    assign m_done        = m_axis_tvalid && m_axis_tready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pos_col   = cnt_col;
        pos_row   = cnt_row;
        pos_idx   = cnt_idx_in_burst;
        if (sof) begin
            pos_col = '0;
            pos_row = '0;
            pos_idx = '0;
        end
        is_final  = take && (pos_idx == IW'(PPB - 1));

        load_data = '0;
        for (int k = 0; k < PPB - 1; k++) begin
            load_data[k*W +: W] = buffer[k];
        end
        load_data[(PPB-1)*W +: W] = s_axis_tdata;

        load_user    = '0;
        load_user[0] = first_flag;
        load_user[1] = (pos_col == CW'(COLS - 1));
        load_last    = (pos_row == RW'(ROWS - 1)) && (pos_col == CW'(COLS - 1));
    end

    // NOTE: the assembly buffer is explicitly cleared on reset so no stale partial burst survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= WAIT_SOF;
            running          <= 1'b0;
            cnt_col          <= '0;
            cnt_row          <= '0;
            cnt_idx_in_burst <= '0;
            first_flag       <= 1'b0;
            frame_err        <= 1'b0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tuser     <= '0;
            m_axis_tlast     <= 1'b0;
            for (int k = 0; k < PPB - 1; k++) begin
                buffer[k] <= '0;
            end
        end else begin
            running   <= 1'b1;
            frame_err <= accept && (state == ACTIVE) && sof
                         && ((cnt_row != '0) || (cnt_col != '0));

            if (take) begin
                if (is_final) begin
                    cnt_idx_in_burst <= '0;
                end else begin
                    buffer[pos_idx]  <= s_axis_tdata;
                    cnt_idx_in_burst <= pos_idx + IW'(1);
                    if (pos_idx == '0) begin
                        first_flag <= (pos_row == '0) && (pos_col == '0);
                    end
                end

                if (pos_col == CW'(COLS - 1)) begin
                    cnt_col <= '0;
                    if (pos_row == RW'(ROWS - 1)) begin
                        cnt_row <= '0;
                        state   <= WAIT_SOF;
                    end else begin
                        cnt_row <= pos_row + RW'(1);
                        state   <= ACTIVE;
                    end
                end else begin
                    cnt_col <= pos_col + CW'(1);
                    cnt_row <= pos_row;
                    state   <= ACTIVE;
                end
            end

            // A final pixel is only accepted when the register is free or draining this cycle.
            if (is_final) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= load_data;
                m_axis_tuser  <= load_user;
                m_axis_tlast  <= load_last;
            end else if (m_done) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tuser  <= '0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parallelizer.sv
// Directed bench for parallelizer: 4x20 frames, 10-pixel bursts, ramp data so lane k of
// frame burst b carries 10b+k.
module tb_parallelizer;

    localparam int W    = 10;
    localparam int PPB  = 10;
    localparam int UW   = 2;
    localparam int ROWS = 4;
    localparam int COLS = 20;
    localparam int DW   = W * PPB;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } burst_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       s_tvalid;
    logic                       s_tready;
    logic [W-1:0]               s_tdata;
    logic [UW-1:0]              s_tuser;
    logic                       m_tvalid;
    logic                       m_tready;
    logic [DW-1:0]              m_tdata;
    logic [UW-1:0]              m_tuser;
    logic                       m_tlast;
    logic [$clog2(COLS)-1:0]    cnt_col;
    logic [$clog2(ROWS)-1:0]    cnt_row;
    logic                       frame_err;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     err_pulses = 0;
    burst_t q[$];

    parallelizer #(
        .PIXEL_BIT_WIDTH (W),
        .PIXELS_PER_BURST(PPB),
        .USER_WIDTH      (UW),
        .ROWS            (ROWS),
        .COLS            (COLS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tuser (s_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tuser (m_tuser),
        .m_axis_tlast (m_tlast),
        .cnt_col      (cnt_col),
        .cnt_row      (cnt_row),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_tvalid && m_tready) q.push_back({m_tdata, m_tuser, m_tlast});
        if (frame_err) err_pulses <= err_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int fb);
        logic [DW-1:0] e;
        e = '0;
        for (int k = 0; k < PPB; k++) e[k*W +: W] = W'(10 * fb + k);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic sof);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = {1'b0, sof};
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixel %0d observed ready 0 expected 1", d);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic ramp(input int lo, input int hi, input bit sof_first);
        for (int v = lo; v <= hi; v++) send(W'(v), sof_first && (v == lo));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare queue entries qi.. against frame bursts fb0.. of a 0..79 ramp.
    task automatic check_bursts(input int qi, input int n, input int fb0, input string tag);
        burst_t b;
        int     fb;
        for (int i = 0; i < n; i++) begin
            fb = fb0 + i;
            b  = (qi + i < q.size()) ? q[qi + i] : 'x;
            check($sformatf("%s_data%0d", tag, i), b.data, exp_data(fb));
            check($sformatf("%s_user%0d", tag, i), b.user, {fb % 2 == 1, fb == 0});
            check($sformatf("%s_last%0d", tag, i), b.last, fb == 7);
        end
    endtask

    initial begin
        int     err0;
        int     c0;
        int     lasts;
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;

        // Reset state
        #12;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_cnt_col", cnt_col, 0);
        check("rst_cnt_row", cnt_row, 0);
        check("rst_frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        check("post_rst_s_tready", s_tready, 1);

        // 1: single ramp frame
        q.delete();
        ramp(0, 8, 1);
        check("t1_valid_early", m_tvalid, 0);
        send(W'(9), 1'b0);
        check("t1_valid_latency", m_tvalid, 1);
        check("t1_col_after9", cnt_col, 10);
        ramp(10, 25, 0);
        check("t1_col_after25", cnt_col, 6);
        check("t1_row_after25", cnt_row, 1);
        ramp(26, 79, 0);
        check("t1_col_end", cnt_col, 0);
        check("t1_row_end", cnt_row, 0);
        idle(3);
        check("t1_count", q.size(), 8);
        check_bursts(0, 8, 0, "t1");

        // 2: pixels before SOF are dropped
        q.delete();
        for (int v = 500; v <= 504; v++) send(W'(v), 1'b0);
        check("t2_col_held", cnt_col, 0);
        check("t2_no_output", m_tvalid, 0);
        ramp(0, 79, 1);
        idle(3);
        check("t2_count", q.size(), 8);
        check_bursts(0, 8, 0, "t2");

        // 3: back-pressure on the final pixel of burst 1
        q.delete();
        m_tready = 1'b0;
        ramp(0, 18, 1);
        s_tvalid = 1'b1;
        s_tdata  = W'(19);
        s_tuser  = '0;
        @(negedge clk);
        check("t3_stall_ready", s_tready, 0);
        check("t3_stall_valid", m_tvalid, 1);
        check("t3_stall_data", m_tdata, exp_data(0));
        repeat (3) @(negedge clk);
        check("t3_hold_ready", s_tready, 0);
        check("t3_hold_data", m_tdata, exp_data(0));
        check("t3_hold_user", m_tuser, 2'b01);
        check("t3_none_out", q.size(), 0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", s_tready, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check("t3_no_bubble", m_tvalid, 1);
        check("t3_one_out", q.size(), 1);
        check("t3_burst1_data", m_tdata, exp_data(1));
        ramp(20, 79, 0);
        idle(3);
        check("t3_count", q.size(), 8);
        check_bursts(0, 8, 0, "t3");

        // 4: SOF mid-frame restarts at pixel position 35
        q.delete();
        err0 = err_pulses;
        ramp(0, 34, 1);
        check("t4_no_err", frame_err, 0);
        send(W'(0), 1'b1);
        check("t4_err_pulse", frame_err, 1);
        check("t4_col_restart", cnt_col, 1);
        check("t4_row_restart", cnt_row, 0);
        send(W'(1), 1'b0);
        check("t4_err_cleared", frame_err, 0);
        ramp(2, 79, 0);
        idle(3);
        check("t4_err_count", err_pulses - err0, 1);
        check("t4_count", q.size(), 11);
        check_bursts(0, 3, 0, "t4a");
        check_bursts(3, 8, 0, "t4b");

        // 5: async reset mid-burst with a burst held in the output register
        q.delete();
        m_tready = 1'b0;
        ramp(0, 12, 1);
        check("t5_pre_valid", m_tvalid, 1);
        check("t5_pre_col", cnt_col, 13);
        s_tvalid = 1'b1;
        s_tdata  = W'(13);
        s_tuser  = '0;
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", m_tvalid, 0);
        check("t5_rst_data", m_tdata, 0);
        check("t5_rst_user", m_tuser, 0);
        check("t5_rst_col", cnt_col, 0);
        check("t5_rst_ready", s_tready, 0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_tready = 1'b1;
        idle(1);
        check("t5_nothing_out", q.size(), 0);
        ramp(0, 79, 1);
        idle(3);
        check("t5_count", q.size(), 8);
        check_bursts(0, 8, 0, "t5");

        // 6: two back-to-back frames at full rate
        q.delete();
        c0 = cyc;
        ramp(0, 79, 1);
        ramp(0, 79, 1);
        check("t6_cycles", cyc - c0, 160);
        idle(3);
        check("t6_count", q.size(), 16);
        check_bursts(0, 8, 0, "t6a");
        check_bursts(8, 8, 0, "t6b");
        lasts = 0;
        foreach (q[i]) if (q[i].last) lasts++;
        check("t6_tlast_count", lasts, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
